inst_fetch_buffer: RTL and testbench
====================================

// Module: inst_fetch_buffer
// PURPOSE
//  Parametrised successor fetch stage: drives an SRAM-like instruction port (req/addr_ok/data_ok),
//  keeps up to MAX_OUT requests in flight, and queues returned {pc,inst} in a DEPTH-entry buffer
//  ahead of decode. Redirects (flush) drop buffered and in-flight fetches. Sits between PC logic and ID.
// PARAMETERS
//  RESET_PC  32'hbfc00000  fetch address loaded at reset
//  DEPTH     4             instruction buffer entries (power of 2, >=2)
//  MAX_OUT   2             max requests issued but not returned (power of 2, >=1)
// PORTS
//  clk           in   1   clock, rising edge
//  resetn        in   1   asynchronous active-low reset
//  flush         in   1   redirect fetch to flush_pc this cycle
//  flush_pc      in   32  redirect target, word aligned
//  inst_req      out  1   request valid to instruction memory
//  inst_addr     out  32  request address, stable while inst_req && !inst_addr_ok
//  inst_addr_ok  in   1   request accepted this cycle
//  inst_rdata    in   32  returned instruction, valid with inst_data_ok
//  inst_data_ok  in   1   one response, in request order
//  out_valid     out  1   buffer head valid
//  out_ready     in   1   decode accepts head (stall = !out_ready)
//  out_pc        out  32  pc of head instruction
//  out_inst      out  32  head instruction
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, outstanding=0, discard=0,
//    buffer empty, out_valid=0, out_pc/out_inst=0.
//  - Credit: issue allowed when outstanding + buf_count < DEPTH and outstanding < MAX_OUT.
//  - inst_req asserts when credit allows and no flush this cycle; inst_addr=fetch_pc.
//  - Handshake: accept = inst_req & inst_addr_ok -> fetch_pc+=4, outstanding+1, pc pushed to tag FIFO.
//    Once raised, inst_req and inst_addr hold until inst_addr_ok (no retraction, even on flush).
//  - Response: inst_data_ok pops tag FIFO; if discard>0 then discard-1 and data dropped, else
//    {tag_pc,inst_rdata} pushed to buffer. outstanding-1 in either case. Accept+response same cycle: net 0.
//  - Output: out_valid = buffer non-empty; pop on out_valid & out_ready. Fall-through not required:
//    min latency data_ok -> out_valid = 1 cycle. Push and pop same cycle allowed at full.
//  - Flush (highest priority): buffer cleared next cycle; fetch_pc<=flush_pc;
//    discard <= outstanding_next (incl. an accept this cycle, excl. a response this cycle);
//    if inst_req pending without addr_ok, it is marked stale: completes with old addr, counted as discard.
//    Back-to-back flushes: last target wins; discard accumulates correctly.
//  - No response may arrive with outstanding==0 (assertion). pc arithmetic wraps mod 2^32.
//  - Counters sized $clog2(MAX_OUT+1) / $clog2(DEPTH+1); never overflow by construction.
//  - FSM (request channel): IDLE (no req) -> REQ (req high) -> IDLE on addr_ok unless credit allows
//    next issue (stay REQ with new addr); REQ_STALE when flushed while REQ; REQ_STALE -> IDLE on addr_ok.
// STRUCTURE
//  - Shared pkg: RESET_PC default, INST_W=32, ADDR_W=32, fetch request FSM state encoding.
//  - Sub-module sync_fifo (WIDTH, DEPTH, sync clear): one instance for tags (32b x MAX_OUT),
//    one for buffer (64b x DEPTH). Credit, discard, FSM in top level.
// TESTING
//  - Reset, addr_ok=1, data_ok 1 cycle later, out_ready=1 -> pcs bfc00000,bfc00004,... in order, no gaps.
//  - out_ready=0 with DEPTH=4 -> exactly 4 entries buffered, inst_req drops, no 5th accept.
//  - 2 in flight, flush to 80000100 -> both responses dropped, next out_pc=80000100.
//  - Flush while inst_req high, addr_ok=0 -> addr held until accept, response discarded, then 80000100.
//  - Flush coincident with data_ok and accept -> discard count exact; no stale instruction appears.
//  - resetn low mid-transfer -> outputs at reset values immediately (async); refetch from bfc00000.

Source files
------------

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: widths, reset vector and
// the request-channel state encoding.
package inst_fetch_buffer_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hbfc00000;

   typedef enum logic [1:0] {
      FETCH_IDLE      = 2'd0,
      FETCH_REQ       = 2'd1,
      FETCH_REQ_STALE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// Small synchronous FIFO with a synchronous clear. The head is read
// combinationally, so push and pop in the same cycle work even when full.
module inst_fetch_buffer_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: issues pipelined requests to the instruction port, tags them with
// their pc and queues returned {pc,inst} for decode. A flush redirects fetch.
module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                DEPTH    = 4,
   parameter int                MAX_OUT  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic [INST_W-1:0] inst_rdata,
   input  logic              inst_data_ok,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   output fetch_state_t      state
);

   localparam int OW = $clog2(MAX_OUT+1);
   localparam int BW = $clog2(DEPTH+1);
   localparam int SW = ((OW > BW) ? OW : BW) + 1;

   fetch_state_t       next_state;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  stale_addr;
   logic [OW-1:0]      outstanding;
   logic [OW-1:0]      out_next;
   logic [OW-1:0]      discard;
   logic [OW-1:0]      tag_count;
   logic [BW-1:0]      buf_count;
   logic [BW-1:0]      buf_next;
   logic [ADDR_W-1:0]  tag_pc;
   logic [ADDR_W+INST_W-1:0] buf_head;
   logic accept, keep, buf_pop, can_issue, stale_pending;

   assign accept        = inst_req & inst_addr_ok;
   assign keep          = inst_data_ok & (discard == '0);
   assign buf_pop       = out_valid & out_ready;
   assign stale_pending = inst_req & ~inst_addr_ok;

   // Credit is judged on next-cycle occupancy so a request raised now always has room.
   always_comb begin
      out_next = outstanding;
      if (accept && !inst_data_ok)      out_next = outstanding + OW'(1);
      else if (!accept && inst_data_ok) out_next = outstanding - OW'(1);
      buf_next = buf_count;
      if (flush)                  buf_next = '0;
      else if (keep && !buf_pop)  buf_next = buf_count + BW'(1);
      else if (!keep && buf_pop)  buf_next = buf_count - BW'(1);
      can_issue = (SW'(out_next) + SW'(buf_next) < SW'(DEPTH)) && (out_next < OW'(MAX_OUT));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= FETCH_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH_IDLE:      if (!flush && can_issue) next_state = FETCH_REQ;
         FETCH_REQ: begin
            if (flush)             next_state = inst_addr_ok ? FETCH_IDLE : FETCH_REQ_STALE;
            else if (inst_addr_ok) next_state = can_issue ? FETCH_REQ : FETCH_IDLE;
         end
         FETCH_REQ_STALE: if (inst_addr_ok) next_state = FETCH_IDLE;
         default:         next_state = FETCH_IDLE;
      endcase
   end

   always_comb begin
      inst_req  = (state != FETCH_IDLE);
      inst_addr = (state == FETCH_REQ_STALE) ? stale_addr : fetch_pc;
   end

   // A stale request still counts as one response to drop, hence stale_pending.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc    <= RESET_PC;
         stale_addr  <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= out_next;
         if (flush) begin
            fetch_pc <= flush_pc;
            discard  <= out_next + OW'(stale_pending);
            if (state == FETCH_REQ && !inst_addr_ok) stale_addr <= fetch_pc;
         end else begin
            if (accept && state == FETCH_REQ) fetch_pc <= fetch_pc + 32'd4;
            if (inst_data_ok && discard != '0) discard <= discard - OW'(1);
         end
      end
   end

   inst_fetch_buffer_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_tag_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (1'b0),
      .push      (accept),
      .push_data (inst_addr),
      .pop       (inst_data_ok),
      .head      (tag_pc),
      .count     (tag_count)
   );

   inst_fetch_buffer_sync_fifo #(.WIDTH(ADDR_W+INST_W), .DEPTH(DEPTH)) u_inst_buf (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (flush),
      .push      (keep),
      .push_data ({tag_pc, inst_rdata}),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (buf_count)
   );

   assign out_valid = (buf_count != '0);
   assign out_pc    = out_valid ? buf_head[ADDR_W+INST_W-1:INST_W] : '0;
   assign out_inst  = out_valid ? buf_head[INST_W-1:0] : '0;

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
      !(inst_data_ok && outstanding == '0));
   a_tag_tracks: assert property (@(posedge clk) disable iff (!resetn)
      tag_count == outstanding);

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with a one-cycle-latency memory responder.
module tb_inst_fetch_buffer;
   import inst_fetch_buffer_pkg::*;

   localparam logic [31:0] MAGIC  = 32'h1234_5678;
   localparam logic [31:0] RST_PC = 32'hbfc00000;
   localparam logic [31:0] TGT    = 32'h80000100;

   logic        clk = 1'b0;
   logic        resetn, flush, inst_req, inst_addr_ok, inst_data_ok;
   logic        out_valid, out_ready;
   logic [31:0] flush_pc, inst_addr, inst_rdata, out_pc, out_inst;
   fetch_state_t state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic addr_ok_en, resp_en;
   logic [31:0] pend_q[$];
   int          pend_t[$];
   logic [31:0] acc_q[$];
   logic [31:0] got_pc_q[$];
   logic [31:0] got_inst_q[$];
   logic [31:0] exp_q[$];

   inst_fetch_buffer dut (
      .clk(clk), .resetn(resetn), .flush(flush), .flush_pc(flush_pc),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .state(state)
   );

   always #5 clk = ~clk;

   // Memory model: accepts when enabled, answers in order one cycle after accept.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!resetn) begin
         pend_q.delete();
         pend_t.delete();
         inst_addr_ok = 1'b0;
         inst_data_ok = 1'b0;
      end else begin
         inst_data_ok = 1'b0;
         if (resp_en && pend_q.size() > 0 && pend_t[0] <= cyc) begin
            inst_data_ok = 1'b1;
            inst_rdata   = pend_q[0] ^ MAGIC;
            void'(pend_q.pop_front());
            void'(pend_t.pop_front());
         end
         inst_addr_ok = addr_ok_en;
         if (inst_req && inst_addr_ok) begin
            pend_q.push_back(inst_addr);
            pend_t.push_back(cyc + 1);
            acc_q.push_back(inst_addr);
         end
      end
   end

   always @(negedge clk) begin
      if (resetn && out_valid && out_ready && !flush) begin
         got_pc_q.push_back(out_pc);
         got_inst_q.push_back(out_inst);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
      addr_ok_en = 1'b0; resp_en = 1'b1;
      repeat (2) tick();
      got_pc_q.delete(); got_inst_q.delete(); acc_q.delete();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
      addr_ok_en = 1'b0; resp_en = 1'b1; inst_rdata = '0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      repeat (2) tick();
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", inst_req); end
      n_checks++; if (inst_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", inst_addr, RST_PC); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", out_inst); end
      resetn = 1'b1;
      tick();
      n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", inst_req); end
      n_checks++; if (inst_addr !== RST_PC) begin n_fail++; $display("FAIL first_addr: got %h want %h", inst_addr, RST_PC); end
   endtask

   task automatic test_stream();
      do_reset();
      addr_ok_en = 1'b1; out_ready = 1'b1;
      repeat (30) tick();
      n_checks++; if (got_pc_q.size() < 10) begin n_fail++; $display("FAIL stream_count: got %0d want >=10", got_pc_q.size()); end
      exp_q.delete();
      for (int i = 0; i < got_pc_q.size(); i++) exp_q.push_back(RST_PC + 32'(4 * i));
      for (int i = 0; i < got_pc_q.size(); i++) begin
         n_checks++; if (got_pc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got_pc_q[i], exp_q[i]); end
         n_checks++; if (got_inst_q[i] !== (exp_q[i] ^ MAGIC)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", i, got_inst_q[i], exp_q[i] ^ MAGIC); end
      end
   endtask

   task automatic test_stall_full();
      do_reset();
      addr_ok_en = 1'b1; out_ready = 1'b0;
      repeat (12) tick();
      n_checks++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL full_accepts: got %0d want 4", acc_q.size()); end
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b want 0", inst_req); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", out_valid); end
      n_checks++; if (out_pc !== RST_PC) begin n_fail++; $display("FAIL full_head: got %h want %h", out_pc, RST_PC); end
      out_ready = 1'b1;
      repeat (12) tick();
      n_checks++; if (got_pc_q.size() < 6) begin n_fail++; $display("FAIL full_drain_count: got %0d want >=6", got_pc_q.size()); end
      exp_q.delete();
      for (int i = 0; i < got_pc_q.size(); i++) exp_q.push_back(RST_PC + 32'(4 * i));
      for (int i = 0; i < got_pc_q.size(); i++) begin
         n_checks++; if (got_pc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_drain_pc[%0d]: got %h want %h", i, got_pc_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_flush_inflight();
      bit found;
      do_reset();
      addr_ok_en = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (acc_q.size() == 2) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL inflight_setup: got %0d accepts want 2", acc_q.size()); end
      tick();
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL inflight_credit: got req %b want 0", inst_req); end
      flush = 1'b1; flush_pc = TGT;
      tick();
      flush = 1'b0; resp_en = 1'b1;
      repeat (16) tick();
      n_checks++; if (got_pc_q.size() < 2) begin n_fail++; $display("FAIL inflight_count: got %0d want >=2", got_pc_q.size()); end
      n_checks++; if (got_pc_q[0] !== TGT) begin n_fail++; $display("FAIL inflight_pc0: got %h want %h", got_pc_q[0], TGT); end
      n_checks++; if (got_pc_q[1] !== TGT + 32'd4) begin n_fail++; $display("FAIL inflight_pc1: got %h want %h", got_pc_q[1], TGT + 32'd4); end
      n_checks++; if (acc_q[2] !== TGT) begin n_fail++; $display("FAIL inflight_addr2: got %h want %h", acc_q[2], TGT); end
   endtask

   task automatic test_flush_pending();
      bit found;
      do_reset();
      addr_ok_en = 1'b0; out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (inst_req) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL pending_setup: got req %b want 1", inst_req); end
      flush = 1'b1; flush_pc = TGT;
      tick();
      flush = 1'b0;
      n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL pending_hold_req: got %b want 1", inst_req); end
      n_checks++; if (inst_addr !== RST_PC) begin n_fail++; $display("FAIL pending_hold_addr: got %h want %h", inst_addr, RST_PC); end
      n_checks++; if (state !== FETCH_REQ_STALE) begin n_fail++; $display("FAIL pending_state: got %0d want %0d", state, FETCH_REQ_STALE); end
      repeat (2) tick();
      n_checks++; if (inst_addr !== RST_PC) begin n_fail++; $display("FAIL pending_hold_addr2: got %h want %h", inst_addr, RST_PC); end
      addr_ok_en = 1'b1;
      repeat (12) tick();
      n_checks++; if (acc_q[0] !== RST_PC) begin n_fail++; $display("FAIL pending_acc0: got %h want %h", acc_q[0], RST_PC); end
      n_checks++; if (acc_q[1] !== TGT) begin n_fail++; $display("FAIL pending_acc1: got %h want %h", acc_q[1], TGT); end
      n_checks++; if (got_pc_q[0] !== TGT) begin n_fail++; $display("FAIL pending_pc0: got %h want %h", got_pc_q[0], TGT); end
      n_checks++; if (got_pc_q[1] !== TGT + 32'd4) begin n_fail++; $display("FAIL pending_pc1: got %h want %h", got_pc_q[1], TGT + 32'd4); end
   endtask

   task automatic test_flush_coincident();
      bit found;
      int pre_n;
      do_reset();
      addr_ok_en = 1'b1; out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (inst_req && inst_addr_ok && inst_data_ok && got_pc_q.size() >= 2) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL coinc_setup: no accept+response cycle got %b want 1", found); end
      flush = 1'b1; flush_pc = TGT;
      @(negedge clk);
      #1;
      pre_n = got_pc_q.size();
      tick();
      flush = 1'b0;
      repeat (15) tick();
      for (int i = 0; i < pre_n; i++) begin
         n_checks++; if (got_pc_q[i] !== RST_PC + 32'(4 * i)) begin n_fail++; $display("FAIL coinc_pre[%0d]: got %h want %h", i, got_pc_q[i], RST_PC + 32'(4 * i)); end
      end
      n_checks++; if (got_pc_q.size() < pre_n + 4) begin n_fail++; $display("FAIL coinc_count: got %0d want >=%0d", got_pc_q.size(), pre_n + 4); end
      for (int i = pre_n; i < got_pc_q.size(); i++) begin
         n_checks++; if (got_pc_q[i] !== TGT + 32'(4 * (i - pre_n))) begin n_fail++; $display("FAIL coinc_post[%0d]: got %h want %h", i, got_pc_q[i], TGT + 32'(4 * (i - pre_n))); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      addr_ok_en = 1'b1; out_ready = 1'b1;
      repeat (6) tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got valid %b want 1", out_valid); end
      #1;
      resetn = 1'b0;
      #1;
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL areset_req: got %b want 0", inst_req); end
      n_checks++; if (inst_addr !== RST_PC) begin n_fail++; $display("FAIL areset_addr: got %h want %h", inst_addr, RST_PC); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_valid); end
      n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h want 0", out_pc); end
      n_checks++; if (state !== FETCH_IDLE) begin n_fail++; $display("FAIL areset_state: got %0d want %0d", state, FETCH_IDLE); end
      repeat (2) tick();
      got_pc_q.delete(); got_inst_q.delete(); acc_q.delete();
      resetn = 1'b1;
      repeat (10) tick();
      n_checks++; if (acc_q[0] !== RST_PC) begin n_fail++; $display("FAIL areset_refetch: got %h want %h", acc_q[0], RST_PC); end
      n_checks++; if (got_pc_q[0] !== RST_PC) begin n_fail++; $display("FAIL areset_pc0: got %h want %h", got_pc_q[0], RST_PC); end
      n_checks++; if (got_pc_q[1] !== RST_PC + 32'd4) begin n_fail++; $display("FAIL areset_pc1: got %h want %h", got_pc_q[1], RST_PC + 32'd4); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_full();
      test_flush_inflight();
      test_flush_pending();
      test_flush_coincident();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
